mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS datapath; the parametrised successor of the single-cycle decoder. It sequences each instruction through IF/ID/EXE/MEM/WB states and stretches IF and MEM by a configurable memory latency. It supports addu, subu, jr, ori, lui, lw, sw, beq, j and jal, and traps illegal encodings. It sits between the instruction register (op/func) plus the ALU zero flag and every datapath enable and mux select.

## Interface
- MEM_LAT, 1, cycles per IM/DM access (≥1); IF and MEM each last MEM_LAT cycles
- RA_REG, 31, link register index driven on ra_idx for jal
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26], valid from ID onward
- func  in  6  IR[5:0]
- zero  in  1  ALU equal flag, sampled in EXE
- pcwrite  out  1  PC load enable
- npcsel  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr)
- irwrite  out  1  IR load enable
- regwrite  out  1  GRF write enable
- regdst  out  2  00 rt, 01 rd, 10 ra_idx
- ra_idx  out  5  constant RA_REG
- wdsel  out  2  00 ALU result, 01 DM data, 10 PC+4
- alusrc  out  1  0 RD2, 1 extended immediate
- extop  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- aluop  out  2  00 add, 01 sub, 10 decode func, 11 or
- memwrite  out  1  DM write enable
- state  out  3  current state, for debug
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse in ID for an unsupported op/func

## Operation
- States: IF, ID, EXE, MEM, WB. A wait counter of width $clog2(MEM_LAT+1) runs in IF and MEM only.
- IF: stays for MEM_LAT cycles. irwrite=1 and pcwrite=1 with npcsel=00 on the last cycle only. Then goes to ID.
- ID: decodes the class.
  - j: pcwrite, npcsel=10.
  - jr (op 0, func 001000): pcwrite, npcsel=11.
  - jal: pcwrite, npcsel=10, regwrite, regdst=10, wdsel=10.
  - j/jr/jal go to IF with instr_done=1.
  - Illegal: illegal=1, instr_done=1, no enables, go to IF.
  - Everything else goes to EXE.
- EXE:
  - R-type: alusrc=0, aluop=10, go to WB.
  - ori: alusrc=1, extop=00, aluop=11, go to WB.
  - lui: alusrc=1, extop=10, aluop=00, go to WB.
  - lw/sw: alusrc=1, extop=01, aluop=00, go to MEM.
  - beq: alusrc=0, aluop=01, pcwrite=zero, npcsel=01, instr_done=1, go to IF.
- MEM: stays for MEM_LAT cycles.
  - sw: memwrite=1 on the last cycle only, instr_done=1 there, then go to IF.
  - lw: go to WB after the last cycle.
- WB: regwrite=1.
  - R-type: regdst=01, wdsel=00.
  - ori/lui: regdst=00, wdsel=00.
  - lw: regdst=00, wdsel=01.
  - instr_done=1, go to IF.
- Outputs are combinational from state, counter and decoded class. Every enable not listed for a state is 0. Every select not listed is 00.
- Within a state, select values are held stable for all cycles.

## Timing
- Cycles per instruction:
  - j/jr/jal/illegal: MEM_LAT+1
  - beq: MEM_LAT+2
  - R/ori/lui: MEM_LAT+3
  - sw: 2·MEM_LAT+2
  - lw: 2·MEM_LAT+3
- Reset, sampled at a rising edge:
  - Next state is IF with counter 0.
  - While reset is high, every output is 0 except ra_idx=RA_REG.
  - state reads IF.
  - Reset in any state aborts the instruction. No write enable is asserted in the cycle reset is high.
- Counter wrap: clears on leaving IF or MEM. With MEM_LAT=1, IF and MEM are single cycles and the counter stays 0.
- op/func must be stable from ID through the end of the instruction; the IR changes only on irwrite.
- beq samples zero combinationally in its single EXE cycle. Not-taken beq asserts no pcwrite in EXE, because PC+4 was already loaded in IF.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding localparams
  - opcode/func constants (R 000000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, jr func 001000, addu 100001, subu 100011)
  - npcsel/regdst/wdsel/extop/aluop encodings
- Sub-module mc_decode: combinational op/func → one-hot class (rtype, jr, ori, lui, lw, sw, beq, j, jal, illegal).
- mc_ctrl holds the FSM, the counter and the output logic.

## Test plan
- MEM_LAT=1, addu (op 0, func 100001) after reset:
  - IF cycle 1: irwrite=pcwrite=1.
  - EXE: aluop=10.
  - WB: regwrite=1, regdst=01.
  - instr_done in cycle 4.
- MEM_LAT=3, lw:
  - irwrite only in IF cycle 3.
  - MEM lasts 3 cycles.
  - WB: wdsel=01.
  - 9 cycles total.
- MEM_LAT=2, sw: memwrite high for exactly 1 cycle (MEM cycle 2), regwrite never high, 6 cycles.
- beq:
  - zero=1: EXE asserts pcwrite=1, npcsel=01.
  - zero=0: EXE asserts pcwrite=0.
- jal: in ID, pcwrite=1, npcsel=10, regwrite=1, regdst=10, wdsel=10, ra_idx=31.
- Corner cases:
  - op 111111: illegal pulse in ID, then back to IF with no enables asserted.
  - reset asserted mid-MEM of sw: memwrite stays 0, and after deassert state=IF.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/func constants, datapath select encodings and the decoded class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  typedef struct packed {
    logic rtype;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } mc_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder producing a one-hot instruction class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output mc_class_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        if (func == FN_ADDU || func == FN_SUBU) cls.rtype = 1'b1;
        else if (func == FN_JR)                 cls.jr = 1'b1;
        else                                    cls.illegal = 1'b1;
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw = 1'b1;
      OP_SW:   cls.sw = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing with IF and MEM
// stretched to MEM_LAT cycles, driving every datapath enable and select.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RA_REG  = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       pcwrite,
  output logic [1:0] npcsel,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [4:0] ra_idx,
  output logic [1:0] wdsel,
  output logic       alusrc,
  output logic [1:0] extop,
  output logic [1:0] aluop,
  output logic       memwrite,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam int unsigned    CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT - 1);

  state_t        cur;
  logic [CW-1:0] cnt;
  logic          last;
  mc_class_t     cls;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  assign last   = (cnt == CNT_LAST);
  assign ra_idx = 5'(RA_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_IF;
      cnt <= '0;
    end else begin
      case (cur)
        S_IF: begin
          if (last) begin
            cur <= S_ID;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ID: begin
          if (cls.j || cls.jr || cls.jal || cls.illegal) cur <= S_IF;
          else                                          cur <= S_EXE;
        end
        S_EXE: begin
          if (cls.beq)                cur <= S_IF;
          else if (cls.lw || cls.sw)  cur <= S_MEM;
          else                        cur <= S_WB;
        end
        S_MEM: begin
          if (last) begin
            cur <= cls.sw ? S_IF : S_WB;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB:    cur <= S_IF;
        default: cur <= S_IF;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is high so an
  // interrupted instruction never issues a write in the reset cycle.
  always_comb begin
    pcwrite    = 1'b0;
    npcsel     = NPC_PC4;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = RD_RT;
    wdsel      = WD_ALU;
    alusrc     = 1'b0;
    extop      = EXT_ZERO;
    aluop      = ALU_ADD;
    memwrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = reset ? S_IF : cur;
    if (!reset) begin
      case (cur)
        S_IF: begin
          irwrite = last;
          pcwrite = last;
        end
        S_ID: begin
          if (cls.j) begin
            pcwrite    = 1'b1;
            npcsel     = NPC_JMP;
            instr_done = 1'b1;
          end else if (cls.jr) begin
            pcwrite    = 1'b1;
            npcsel     = NPC_RS;
            instr_done = 1'b1;
          end else if (cls.jal) begin
            pcwrite    = 1'b1;
            npcsel     = NPC_JMP;
            regwrite   = 1'b1;
            regdst     = RD_RA;
            wdsel      = WD_PC4;
            instr_done = 1'b1;
          end else if (cls.illegal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXE: begin
          if (cls.rtype) begin
            aluop = ALU_FUNC;
          end else if (cls.ori) begin
            alusrc = 1'b1;
            extop  = EXT_ZERO;
            aluop  = ALU_OR;
          end else if (cls.lui) begin
            alusrc = 1'b1;
            extop  = EXT_LUI;
          end else if (cls.lw || cls.sw) begin
            alusrc = 1'b1;
            extop  = EXT_SIGN;
          end else if (cls.beq) begin
            aluop      = ALU_SUB;
            pcwrite    = zero;
            npcsel     = NPC_BR;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          if (cls.sw && last) begin
            memwrite   = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          if (cls.rtype)   regdst = RD_RD;
          else if (cls.lw) wdsel  = WD_DM;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: three instances (MEM_LAT 1..3) run directed
// instruction lists against a cycle-index model of the instruction timing.
module tb_mc_ctrl;

  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4, C_LW = 5,
                 C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_ILL = 10, C_ILLR = 11,
                 C_RESET = 12;

  typedef struct packed {
    logic       pcwrite;
    logic [1:0] npcsel;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       alusrc;
    logic [1:0] extop;
    logic [1:0] aluop;
    logic       memwrite;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal;
    logic [4:0] ra_idx;
  } ov_t;

  typedef struct packed {
    int inst;
    int c;
    int z;
    int abort_k;
    int lit;
  } vec_t;

  localparam int NV = 24;
  vec_t tab [NV] = '{
    '{0, C_ADDU, 0, -1, 4}, '{0, C_SUBU, 0, -1, 4}, '{0, C_ORI, 0, -1, 4},
    '{0, C_LUI,  0, -1, 4}, '{0, C_BEQ,  1, -1, 3}, '{0, C_BEQ, 0, -1, 3},
    '{0, C_J,    0, -1, 2}, '{0, C_JR,   0, -1, 2}, '{0, C_JAL, 0, -1, 2},
    '{0, C_ILL,  0, -1, 2}, '{0, C_LW,   0, -1, 5}, '{0, C_SW,  0, -1, 4},
    '{1, C_SW,   0, -1, 6}, '{1, C_SW,   0,  5, 0}, '{1, C_ADDU, 0, -1, 5},
    '{1, C_LW,   0, -1, 7}, '{1, C_JAL,  0, -1, 3}, '{1, C_BEQ, 1, -1, 4},
    '{1, C_ILLR, 0, -1, 3}, '{2, C_LW,   0, -1, 9}, '{2, C_SW,  0, -1, 8},
    '{2, C_ORI,  0, -1, 6}, '{2, C_ILL,  0, -1, 4}, '{2, C_BEQ, 0, -1, 5}
  };

  int ntests = 0;
  int nfail  = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string cname(int c);
    case (c)
      C_ADDU: return "addu";
      C_SUBU: return "subu";
      C_JR:   return "jr";
      C_ORI:  return "ori";
      C_LUI:  return "lui";
      C_LW:   return "lw";
      C_SW:   return "sw";
      C_BEQ:  return "beq";
      C_J:    return "j";
      C_JAL:  return "jal";
      C_ILL:  return "illegal_op";
      C_ILLR: return "illegal_func";
      default: return "reset";
    endcase
  endfunction

  function automatic logic [11:0] opfunc(int c);
    case (c)
      C_ADDU: return {6'b000000, 6'b100001};
      C_SUBU: return {6'b000000, 6'b100011};
      C_JR:   return {6'b000000, 6'b001000};
      C_ORI:  return {6'b001101, 6'b001000};
      C_LUI:  return {6'b001111, 6'b100001};
      C_LW:   return {6'b100011, 6'b001000};
      C_SW:   return {6'b101011, 6'b100011};
      C_BEQ:  return {6'b000100, 6'b001000};
      C_J:    return {6'b000010, 6'b100001};
      C_JAL:  return {6'b000011, 6'b001000};
      C_ILLR: return {6'b000000, 6'b000000};
      default: return {6'b111111, 6'b001000};
    endcase
  endfunction

  function automatic int instr_len(int lat, int c);
    case (c)
      C_J, C_JR, C_JAL, C_ILL, C_ILLR: return lat + 1;
      C_BEQ: return lat + 2;
      C_SW:  return 2 * lat + 2;
      C_LW:  return 2 * lat + 3;
      default: return lat + 3;
    endcase
  endfunction

  // Expected outputs for cycle k (0-based) of an instruction of class c.
  function automatic ov_t exp_vec(int lat, int c, int z, int k);
    ov_t v = '0;
    v.ra_idx = 5'd31;
    v.instr_done = (k == instr_len(lat, c) - 1);
    if (k < lat) begin
      v.state = 3'd0;
      v.irwrite = (k == lat - 1);
      v.pcwrite = (k == lat - 1);
    end else if (k == lat) begin
      v.state = 3'd1;
      case (c)
        C_J:   begin v.pcwrite = 1; v.npcsel = 2'b10; end
        C_JR:  begin v.pcwrite = 1; v.npcsel = 2'b11; end
        C_JAL: begin v.pcwrite = 1; v.npcsel = 2'b10; v.regwrite = 1;
                     v.regdst = 2'b10; v.wdsel = 2'b10; end
        C_ILL, C_ILLR: v.illegal = 1;
        default: ;
      endcase
    end else if (k == lat + 1) begin
      v.state = 3'd2;
      case (c)
        C_ADDU, C_SUBU: v.aluop = 2'b10;
        C_ORI: begin v.alusrc = 1; v.extop = 2'b00; v.aluop = 2'b11; end
        C_LUI: begin v.alusrc = 1; v.extop = 2'b10; v.aluop = 2'b00; end
        C_LW, C_SW: begin v.alusrc = 1; v.extop = 2'b01; end
        C_BEQ: begin v.aluop = 2'b01; v.pcwrite = (z != 0); v.npcsel = 2'b01; end
        default: ;
      endcase
    end else if ((c == C_LW || c == C_SW) && k < 2 * lat + 2) begin
      v.state = 3'd3;
      v.memwrite = (c == C_SW && k == 2 * lat + 1);
    end else begin
      v.state = 3'd4;
      v.regwrite = 1;
      v.regdst = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
      v.wdsel = (c == C_LW) ? 2'b01 : 2'b00;
    end
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int unsigned LAT = g + 1;
    logic rst, zero;
    logic [5:0] op, func;
    logic pcwrite, irwrite, regwrite, alusrc, memwrite, instr_done, illegal;
    logic [1:0] npcsel, regdst, wdsel, extop, aluop;
    logic [4:0] ra_idx;
    logic [2:0] state;
    ov_t got, expv;
    int kk, cur_len, cur_lit, cur_c, first_done;
    bit chk = 0;
    bit fin = 0;

    mc_ctrl #(.MEM_LAT(LAT), .RA_REG(31)) dut (
      .clk(clk), .reset(rst), .op(op), .func(func), .zero(zero),
      .pcwrite(pcwrite), .npcsel(npcsel), .irwrite(irwrite), .regwrite(regwrite),
      .regdst(regdst), .ra_idx(ra_idx), .wdsel(wdsel), .alusrc(alusrc),
      .extop(extop), .aluop(aluop), .memwrite(memwrite), .state(state),
      .instr_done(instr_done), .illegal(illegal)
    );

    assign got = '{pcwrite, npcsel, irwrite, regwrite, regdst, wdsel, alusrc,
                   extop, aluop, memwrite, state, instr_done, illegal, ra_idx};

    always @(negedge clk) begin
      if (chk) begin
        if (kk == 0) first_done = 0;
        if (got.instr_done && first_done == 0) first_done = kk + 1;
        ntests++;
        if (got !== expv) begin
          nfail++;
          $display("FAIL lat%0d %s cycle %0d: got %h required %h",
                   LAT, cname(cur_c), kk, got, expv);
        end
        if (cur_lit != 0 && kk == cur_len - 1) begin
          ntests++;
          if (first_done != cur_lit) begin
            nfail++;
            $display("FAIL lat%0d %s length: got %0d required %0d",
                     LAT, cname(cur_c), first_done, cur_lit);
          end
        end
      end
    end

    initial begin
      logic [11:0] of;
      rst = 1; op = '0; func = '0; zero = 0;
      @(posedge clk); #1;
      expv = '0; expv.ra_idx = 5'd31;
      kk = 0; cur_c = C_RESET; cur_lit = 0; cur_len = 1; chk = 1;
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < NV; i++) begin
        if (tab[i].inst == g) begin
          of = opfunc(tab[i].c);
          op = of[11:6]; func = of[5:0]; zero = (tab[i].z != 0);
          cur_c = tab[i].c; cur_lit = tab[i].lit;
          cur_len = instr_len(int'(LAT), tab[i].c);
          for (int k = 0; k < cur_len; k++) begin
            kk = k;
            if (k == tab[i].abort_k) begin
              rst = 1;
              expv = '0; expv.ra_idx = 5'd31;
              @(posedge clk); #1;
              rst = 0;
              break;
            end
            expv = exp_vec(int'(LAT), tab[i].c, tab[i].z, k);
            @(posedge clk); #1;
          end
        end
      end
      chk = 0;
      fin = 1;
    end
  end

  initial begin
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (gi[0].fin && gi[1].fin && gi[2].fin) break;
    end
    if (!(gi[0].fin && gi[1].fin && gi[2].fin)) begin
      ntests++;
      nfail++;
      $display("FAIL timeout: got unfinished stimulus required all instances done");
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
